pc_fetch_ctrl: RTL

- Program-counter register and fetch-sequencing controller for the IF stage.
- Registers the next-PC value selected by the IF next-PC mux, supplies the current PC and PC+4 back to the mux and to instruction memory, and generates the pipeline-advance enable.
- Supports continuous run, single-step debug mode, hazard stall and HALT detection.

---
 rtl/pc_fetch_ctrl_if.sv | 29 ++
 rtl/pc_fetch_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus between the IF next-PC mux / debug / hazard logic and the PC controller.
// The master drives next-PC and control requests; the slave (pc_fetch_ctrl) returns PC state.
interface pc_fetch_ctrl_if #(
    parameter int SIZE_REG_MEM = 32,
    parameter int CNT_WIDTH    = 32
);
    logic [SIZE_REG_MEM-1:0] i_next_pc;
    logic                    i_stall;
    logic                    i_halt;
    logic                    i_start;
    logic                    i_mode_step;
    logic                    i_step;
    logic [SIZE_REG_MEM-1:0] o_pc;
    logic [SIZE_REG_MEM-1:0] o_pc_plus4;
    logic                    o_pc_write;
    logic                    o_pipe_en;
    logic                    o_halted;
    logic [CNT_WIDTH-1:0]    o_cycle_count;

    modport master (
        output i_next_pc, i_stall, i_halt, i_start, i_mode_step, i_step,
        input  o_pc, o_pc_plus4, o_pc_write, o_pipe_en, o_halted, o_cycle_count
    );

    modport slave (
        input  i_next_pc, i_stall, i_halt, i_start, i_mode_step, i_step,
        output o_pc, o_pc_plus4, o_pc_write, o_pipe_en, o_halted, o_cycle_count
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer for the IF stage: run / single-step / stall / HALT,
// plus a saturating count of pipeline-advance cycles.
module pc_fetch_ctrl #(
    parameter int                      SIZE_REG_MEM = 32,
    parameter logic [SIZE_REG_MEM-1:0] PC_RESET     = {SIZE_REG_MEM{1'b0}},
    parameter int                      CNT_WIDTH    = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    pc_fetch_ctrl_if.slave bus
);

    // The run/step mode chosen at start is encoded by which state IDLE leaves to.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_WAIT_STEP = 3'd2,
        ST_STEP      = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [SIZE_REG_MEM-1:0] pc_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic                    step_q_r;
    logic                    step_rise_s;
    logic                    pipe_en_s;
    logic                    halted_s;
    logic                    pc_write_s;
    logic                    halt_take_s;

    assign step_rise_s = bus.i_step & ~step_q_r;
    assign pc_write_s  = pipe_en_s & ~bus.i_stall;
    // A stalled cycle never commits, so HALT is only taken once the stall releases.
    assign halt_take_s = pc_write_s & bus.i_halt;

    assign bus.o_pc          = pc_r;
    assign bus.o_pc_plus4    = pc_r + {{(SIZE_REG_MEM-3){1'b0}}, 3'd4};
    assign bus.o_pc_write    = pc_write_s;
    assign bus.o_pipe_en     = pipe_en_s;
    assign bus.o_halted      = halted_s;
    assign bus.o_cycle_count = cnt_r;

    // State-decoded advance enable and halted flag.
    always_comb begin
        pipe_en_s = 1'b0;
        halted_s  = 1'b0;
        case (state_r)
            ST_RUN:    pipe_en_s = 1'b1;
            ST_STEP:   pipe_en_s = 1'b1;
            ST_HALTED: halted_s  = 1'b1;
            default: begin
                pipe_en_s = 1'b0;
                halted_s  = 1'b0;
            end
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_mode_step) begin
                        state_next_s = ST_WAIT_STEP;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_take_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT_STEP: begin
                if (step_rise_s) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_WAIT_STEP;
                end
            end
            ST_STEP: begin
                if (halt_take_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_WAIT_STEP;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register and step-edge history (tracked in every state).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            step_q_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            step_q_r <= bus.i_step;
        end
    end

    // PC register: word-aligned load of the mux output, held on stall and on HALT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_r <= PC_RESET;
        end else if (pc_write_s && !bus.i_halt) begin
            pc_r <= {bus.i_next_pc[SIZE_REG_MEM-1:2], 2'b00};
        end else begin
            pc_r <= pc_r;
        end
    end

    // Saturating count of cycles with the pipeline enabled, stalls included.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (pipe_en_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule
